// File: rtl/rs232_mem_dumper_if.sv
// rs232_mem_dumper_if: memory read port plus RS232 TX buffer write port seen by the dumper.
interface rs232_mem_dumper_if #(parameter int ADDR_W = 32);
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [31:0]       rd_data;
    logic [7:0]        iData_RS232;
    logic              WriteEnable_RS232;
    logic              oWrBuffer_full_RS232;
    modport master (
        output rd_addr, rd_en, iData_RS232, WriteEnable_RS232,
        input  rd_data, oWrBuffer_full_RS232
    );
    modport slave (
        input  rd_addr, rd_en, iData_RS232, WriteEnable_RS232,
        output rd_data, oWrBuffer_full_RS232
    );
endinterface

// File: rtl/rs232_mem_dumper.sv
// rs232_mem_dumper: reads a block of memory words and streams them as header, MSB-first bytes and an XOR checksum.
module rs232_mem_dumper #(
    parameter int         ADDR_W   = 32,
    parameter int         CNT_W    = 16,
    parameter logic [7:0] HDR_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    rs232_mem_dumper_if.master bus
);
    typedef enum logic [2:0] {IDLE, HDR, RD_REQ, RD_WAIT, SEND, CSUM, DONE} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [31:0]       sh_q, sh_d;
    logic [1:0]        idx_q, idx_d;
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        data_q, data_d;
    logic              wr;
    logic [7:0]        byte_w;
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        byte_w  = state_q == HDR ? HDR_BYTE : state_q == CSUM ? csum_q : sh_q[31:24];
        wr      = (state_q == HDR || state_q == SEND || state_q == CSUM) && !bus.oWrBuffer_full_RS232;
        data_d  = wr ? byte_w : data_q;
        case (state_q)
            IDLE: if (start) begin
                addr_d  = base_addr;
                rem_d   = word_count;
                csum_d  = 8'h00;
                state_d = HDR;
            end
            HDR: if (wr) state_d = rem_q != '0 ? RD_REQ : CSUM;
            RD_REQ: state_d = RD_WAIT;
            RD_WAIT: begin
                sh_d    = bus.rd_data;
                idx_d   = 2'd0;
                state_d = SEND;
            end
            SEND: if (wr) begin
                csum_d = csum_q ^ byte_w;
                sh_d   = {sh_q[23:0], 8'h00};
                idx_d  = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    rem_d   = rem_q - CNT_W'(1);
                    state_d = rem_q != CNT_W'(1) ? RD_REQ : CSUM;
                end
            end
            CSUM: if (wr) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            sh_q    <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            data_q  <= data_d;
        end
    end
    // iData holds the last written byte whenever the buffer stalls the FSM
    assign bus.iData_RS232       = data_d;
    assign bus.WriteEnable_RS232 = wr;
    assign bus.rd_en             = state_q == RD_REQ;
    assign bus.rd_addr           = addr_q;
    assign busy                  = state_q != IDLE && state_q != DONE;
    assign done                  = state_q == DONE;
endmodule

// File: tb/tb_rs232_mem_dumper.sv
// tb_rs232_mem_dumper: directed scenarios for the memory dumper with a 1-cycle-latency memory model.
module tb_rs232_mem_dumper;
    logic        clk = 0, rst = 0, start = 0;
    logic [31:0] base_addr = 0;
    logic [15:0] word_count = 0;
    logic        busy, done;
    rs232_mem_dumper_if #(.ADDR_W(32)) bus();
    rs232_mem_dumper #(.ADDR_W(32), .CNT_W(16), .HDR_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy), .done(done), .bus(bus)
    );
    always #5 clk = ~clk;
    int checks = 0, failures = 0, cyc = 0, acc_cyc = 0;
    int done_cnt = 0, first_cyc = -1, done_cyc = -1, we_full_viol = 0, overlap = 0;
    logic [7:0]  bytes[$];
    logic [31:0] rds[$];
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0010: return 32'h1122_3344;
            32'h0000_0011: return 32'hA0B0_C0D0;
            32'hFFFF_FFFF: return 32'hDEAD_BEEF;
            32'h0000_0000: return 32'h0102_0304;
            default:       return 32'hCAFE_F00D;
        endcase
    endfunction
    always @(posedge clk) begin
        cyc++;
        if (bus.rd_en) bus.rd_data <= mem_word(bus.rd_addr);
    end
    always @(negedge clk) begin
        if (bus.WriteEnable_RS232) begin
            if (bytes.size() == 0) first_cyc = cyc;
            bytes.push_back(bus.iData_RS232);
            if (bus.oWrBuffer_full_RS232) we_full_viol++;
            if (bus.rd_en) overlap++;
        end
        if (bus.rd_en) rds.push_back(bus.rd_addr);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end
    task automatic clear_log();
        bytes.delete();
        rds.delete();
        done_cnt = 0;
        first_cyc = -1;
        done_cyc = -1;
    endtask
    task automatic pulse_start(input logic [31:0] b, input logic [15:0] n);
        @(posedge clk); #1;
        start = 1; base_addr = b; word_count = n;
        @(posedge clk); #1;
        start = 0; base_addr = 32'h5555_5555; word_count = 16'h7;
        acc_cyc = cyc;
    endtask
    task automatic wait_done(input int max);
        int k = 0;
        while (done_cnt == 0 && k < max) begin
            @(posedge clk);
            k++;
        end
        checks++;
        if (done_cnt == 0) begin
            failures++;
            $display("FAIL wait_done: done not seen within %0d cycles", max);
        end
    endtask
    task automatic wait_bytes(input int n, input int max);
        int k = 0;
        while (bytes.size() < n && k < max) begin
            @(posedge clk);
            k++;
        end
        checks++;
        if (bytes.size() < n) begin
            failures++;
            $display("FAIL wait_bytes: got %0d bytes, need %0d", bytes.size(), n);
        end
    endtask
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.WriteEnable_RS232, bus.rd_en, busy, done, bus.iData_RS232, bus.rd_addr} !== 44'h0) begin
            failures++;
            $display("FAIL reset_outputs: we=%b rd_en=%b busy=%b done=%b data=%h addr=%h, need all 0",
                     bus.WriteEnable_RS232, bus.rd_en, busy, done, bus.iData_RS232, bus.rd_addr);
        end
        rst = 1;
        repeat (100) @(posedge clk);
        #1;
        checks++;
        if (bytes.size() != 0 || rds.size() != 0 || done_cnt != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_quiet: writes=%0d reads=%0d dones=%0d busy=%b, need 0/0/0/0",
                     bytes.size(), rds.size(), done_cnt, busy);
        end
    endtask
    task automatic test_two_word();
        logic [7:0] exp[$];
        exp = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'h44};
        clear_log();
        pulse_start(32'h10, 16'd2);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL two_busy: busy=%b, need 1", busy);
        end
        wait_done(100);
        repeat (5) @(posedge clk);
        checks++;
        if (bytes.size() != exp.size()) begin
            failures++;
            $display("FAIL two_len: %0d bytes, need %0d", bytes.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < bytes.size(); i++) begin
            checks++;
            if (bytes[i] !== exp[i]) begin
                failures++;
                $display("FAIL two_byte[%0d]: got %h, need %h", i, bytes[i], exp[i]);
            end
        end
        checks++;
        if (rds.size() != 2 || rds[0] !== 32'h10 || rds[1] !== 32'h11) begin
            failures++;
            $display("FAIL two_reads: n=%0d a0=%h a1=%h, need 2 reads at 10,11",
                     rds.size(), rds.size() > 0 ? rds[0] : 32'hX, rds.size() > 1 ? rds[1] : 32'hX);
        end
        checks++;
        if (first_cyc != acc_cyc) begin
            failures++;
            $display("FAIL two_hdr_latency: header in cycle %0d, need %0d", first_cyc, acc_cyc);
        end
        checks++;
        if (done_cnt != 1 || done_cyc - first_cyc != 14) begin
            failures++;
            $display("FAIL two_timing: dones=%0d hdr_to_done=%0d, need 1 and 14", done_cnt, done_cyc - first_cyc);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL two_busy_end: busy=%b, need 0", busy);
        end
    endtask
    task automatic test_zero_words();
        clear_log();
        pulse_start(32'h10, 16'd0);
        wait_done(50);
        repeat (5) @(posedge clk);
        checks++;
        if (bytes.size() != 2 || bytes[0] !== 8'hA5 || bytes[1] !== 8'h00) begin
            failures++;
            $display("FAIL zero_frame: n=%0d b0=%h b1=%h, need 2 bytes A5 00", bytes.size(),
                     bytes.size() > 0 ? bytes[0] : 8'hX, bytes.size() > 1 ? bytes[1] : 8'hX);
        end
        checks++;
        if (rds.size() != 0 || done_cyc - first_cyc != 2) begin
            failures++;
            $display("FAIL zero_reads_timing: reads=%0d hdr_to_done=%0d, need 0 and 2", rds.size(), done_cyc - first_cyc);
        end
    endtask
    task automatic test_full_stall();
        logic [7:0] exp[$];
        exp = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'h44};
        clear_log();
        pulse_start(32'h10, 16'd2);
        wait_bytes(2, 50);
        #1 bus.oWrBuffer_full_RS232 = 1;
        repeat (5) @(posedge clk);
        #1 bus.oWrBuffer_full_RS232 = 0;
        wait_done(100);
        repeat (5) @(posedge clk);
        checks++;
        if (bytes.size() != exp.size()) begin
            failures++;
            $display("FAIL stall_len: %0d bytes, need %0d", bytes.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < bytes.size(); i++) begin
            checks++;
            if (bytes[i] !== exp[i]) begin
                failures++;
                $display("FAIL stall_byte[%0d]: got %h, need %h", i, bytes[i], exp[i]);
            end
        end
        checks++;
        if (done_cyc - first_cyc != 19) begin
            failures++;
            $display("FAIL stall_timing: hdr_to_done=%0d, need 19", done_cyc - first_cyc);
        end
    endtask
    task automatic test_addr_wrap();
        logic [7:0] exp[$];
        exp = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h26};
        clear_log();
        pulse_start(32'hFFFF_FFFF, 16'd2);
        wait_done(100);
        repeat (3) @(posedge clk);
        checks++;
        if (rds.size() != 2 || rds[0] !== 32'hFFFF_FFFF || rds[1] !== 32'h0) begin
            failures++;
            $display("FAIL wrap_reads: n=%0d a0=%h a1=%h, need FFFFFFFF then 00000000",
                     rds.size(), rds.size() > 0 ? rds[0] : 32'hX, rds.size() > 1 ? rds[1] : 32'hX);
        end
        checks++;
        if (bytes.size() != exp.size()) begin
            failures++;
            $display("FAIL wrap_len: %0d bytes, need %0d", bytes.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < bytes.size(); i++) begin
            checks++;
            if (bytes[i] !== exp[i]) begin
                failures++;
                $display("FAIL wrap_byte[%0d]: got %h, need %h", i, bytes[i], exp[i]);
            end
        end
    endtask
    task automatic test_reset_mid_frame();
        clear_log();
        pulse_start(32'h10, 16'd2);
        wait_bytes(3, 50);
        #1 rst = 0;
        #1;
        checks++;
        if ({bus.WriteEnable_RS232, bus.rd_en, busy, done, bus.iData_RS232, bus.rd_addr} !== 44'h0) begin
            failures++;
            $display("FAIL midreset_outputs: we=%b rd_en=%b busy=%b done=%b data=%h addr=%h, need all 0",
                     bus.WriteEnable_RS232, bus.rd_en, busy, done, bus.iData_RS232, bus.rd_addr);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1;
        repeat (20) @(posedge clk);
        checks++;
        if (bytes.size() != 3 || rds.size() != 1 || done_cnt != 0) begin
            failures++;
            $display("FAIL midreset_quiet: writes=%0d reads=%0d dones=%0d, need 3/1/0", bytes.size(), rds.size(), done_cnt);
        end
    endtask
    task automatic test_ignore_start();
        logic [7:0] exp[$];
        exp = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'h44};
        clear_log();
        pulse_start(32'h10, 16'd2);
        wait_bytes(4, 50);
        pulse_start(32'h11, 16'd1);
        wait_done(100);
        repeat (20) @(posedge clk);
        checks++;
        if (done_cnt != 1 || bytes.size() != exp.size()) begin
            failures++;
            $display("FAIL ignore_single: dones=%0d writes=%0d, need 1 and %0d", done_cnt, bytes.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < bytes.size(); i++) begin
            checks++;
            if (bytes[i] !== exp[i]) begin
                failures++;
                $display("FAIL ignore_byte[%0d]: got %h, need %h", i, bytes[i], exp[i]);
            end
        end
    endtask
    initial begin
        bus.oWrBuffer_full_RS232 = 0;
        test_reset();
        test_two_word();
        test_zero_words();
        test_full_stall();
        test_addr_wrap();
        test_reset_mid_frame();
        test_two_word();
        test_ignore_start();
        checks++;
        if (we_full_viol != 0 || overlap != 0) begin
            failures++;
            $display("FAIL handshake: writes_while_full=%0d we_with_rd_en=%0d, need 0 and 0", we_full_viol, overlap);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
